// File: rtl/game_sequencer.sv
// Inning/half-inning sequencer: tracks batting team, inning and both run totals,
// pulses a half-inning clear between halves and decides the game result.
module game_sequencer #(
    parameter int unsigned NUM_INNINGS = 9,
    parameter int unsigned MAX_INNINGS = 12,
    parameter int unsigned SCORE_MAX   = 99
) (
    input  logic       clk_divided,
    input  logic       reset_n,
    input  logic       change_pulse,
    input  logic [2:0] runs_in,
    output logic       team,
    output logic [3:0] inning,
    output logic       play_enable,
    output logic       half_clear_pulse,
    output logic [6:0] score0,
    output logic [6:0] score1,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] NumInn   = 4'(NUM_INNINGS);
    localparam logic [3:0] MaxInn   = 4'(MAX_INNINGS);
    localparam logic [7:0] ScoreMax = 8'(SCORE_MAX);

    localparam logic [1:0] WinVisitor = 2'b01;
    localparam logic [1:0] WinHome    = 2'b10;
    localparam logic [1:0] WinTie     = 2'b11;

    typedef enum logic [1:0] {StPlay, StChange, StOver} state_t;

    state_t     state_q;
    logic [2:0] runs_clamped;
    logic [6:0] score0_d;
    logic [6:0] score1_d;
    logic       late_inning;

    function automatic logic [6:0] sat_add(input logic [6:0] score, input logic [2:0] runs);
        logic [7:0] sum;
        sum = {1'b0, score} + {5'b0, runs};
        return (sum > ScoreMax) ? ScoreMax[6:0] : sum[6:0];
    endfunction

    // Runs land on the same edge they are sampled, so decisions see the updated totals.
    always_comb begin
        runs_clamped = (runs_in > 3'd4) ? 3'd4 : runs_in;
        score0_d     = score0;
        score1_d     = score1;
        if (state_q == StPlay) begin
            if (team == 1'b0) begin
                score0_d = sat_add(score0, runs_clamped);
            end else begin
                score1_d = sat_add(score1, runs_clamped);
            end
        end
        late_inning = (inning >= NumInn);
    end

    always_ff @(posedge clk_divided or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StPlay;
            team             <= 1'b0;
            inning           <= 4'd1;
            play_enable      <= 1'b1;
            half_clear_pulse <= 1'b0;
            score0           <= 7'd0;
            score1           <= 7'd0;
            game_over        <= 1'b0;
            winner           <= 2'b00;
        end else begin
            unique case (state_q)
                StPlay: begin
                    score0 <= score0_d;
                    score1 <= score1_d;
                    if (team && late_inning && (score1_d > score0_d)) begin
                        // Walk-off: home takes the lead in the bottom of a deciding inning.
                        state_q     <= StOver;
                        play_enable <= 1'b0;
                        game_over   <= 1'b1;
                        winner      <= WinHome;
                    end else if (change_pulse) begin
                        if (!team) begin
                            if (late_inning && (score1_d > score0_d)) begin
                                state_q     <= StOver;
                                play_enable <= 1'b0;
                                game_over   <= 1'b1;
                                winner      <= WinHome;
                            end else begin
                                state_q          <= StChange;
                                play_enable      <= 1'b0;
                                half_clear_pulse <= 1'b1;
                            end
                        end else if (!late_inning) begin
                            state_q          <= StChange;
                            play_enable      <= 1'b0;
                            half_clear_pulse <= 1'b1;
                        end else if (score0_d > score1_d) begin
                            state_q     <= StOver;
                            play_enable <= 1'b0;
                            game_over   <= 1'b1;
                            winner      <= WinVisitor;
                        end else if (inning < MaxInn) begin
                            state_q          <= StChange;
                            play_enable      <= 1'b0;
                            half_clear_pulse <= 1'b1;
                        end else begin
                            state_q     <= StOver;
                            play_enable <= 1'b0;
                            game_over   <= 1'b1;
                            winner      <= WinTie;
                        end
                    end
                end
                StChange: begin
                    state_q          <= StPlay;
                    play_enable      <= 1'b1;
                    half_clear_pulse <= 1'b0;
                    if (!team) begin
                        team <= 1'b1;
                    end else begin
                        team   <= 1'b0;
                        inning <= inning + 4'd1;
                    end
                end
                StOver: begin
                    play_enable      <= 1'b0;
                    half_clear_pulse <= 1'b0;
                end
                default: begin
                    state_q <= StPlay;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: each scenario starts from reset and checks
// hand-computed outputs one cycle at a time.
module tb_game_sequencer;

    logic       clk_divided;
    logic       reset_n;
    logic       change_pulse;
    logic [2:0] runs_in;
    logic       team;
    logic [3:0] inning;
    logic       play_enable;
    logic       half_clear_pulse;
    logic [6:0] score0;
    logic [6:0] score1;
    logic       game_over;
    logic [1:0] winner;

    int n_checks;
    int n_passed;

    game_sequencer #(
        .NUM_INNINGS(9),
        .MAX_INNINGS(12),
        .SCORE_MAX  (99)
    ) dut (
        .clk_divided     (clk_divided),
        .reset_n         (reset_n),
        .change_pulse    (change_pulse),
        .runs_in         (runs_in),
        .team            (team),
        .inning          (inning),
        .play_enable     (play_enable),
        .half_clear_pulse(half_clear_pulse),
        .score0          (score0),
        .score1          (score1),
        .game_over       (game_over),
        .winner          (winner)
    );

    initial clk_divided = 1'b0;
    always #5 clk_divided = ~clk_divided;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are held across the edge, outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_divided);
        #1;
    endtask

    task automatic add_runs(input logic [2:0] r);
        runs_in = r;
        tick();
        runs_in = 3'd0;
    endtask

    task automatic do_change();
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        tick();
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) do_change();
    endtask

    task automatic apply_reset();
        @(negedge clk_divided);
        reset_n      = 1'b0;
        change_pulse = 1'b0;
        runs_in      = 3'd0;
        #2;
        @(negedge clk_divided);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".team"},   int'(team), 0);
        check({tag, ".inning"}, int'(inning), 1);
        check({tag, ".pe"},     int'(play_enable), 1);
        check({tag, ".hc"},     int'(half_clear_pulse), 0);
        check({tag, ".s0"},     int'(score0), 0);
        check({tag, ".s1"},     int'(score1), 0);
        check({tag, ".go"},     int'(game_over), 0);
        check({tag, ".win"},    int'(winner), 0);
    endtask

    initial begin
        n_checks     = 0;
        n_passed     = 0;
        reset_n      = 1'b0;
        change_pulse = 1'b0;
        runs_in      = 3'd0;
        #12;
        check_reset_values("rst");
        @(negedge clk_divided);
        reset_n = 1'b1;

        // Runs in top of 1, with 7 clamped to 4.
        add_runs(3'd3);
        check("runs3.s0", int'(score0), 3);
        add_runs(3'd7);
        check("runs7.s0", int'(score0), 7);
        check("runs7.s1", int'(score1), 0);

        // Half change timing; runs during CHANGE are dropped.
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("chg.hc", int'(half_clear_pulse), 1);
        check("chg.pe", int'(play_enable), 0);
        runs_in = 3'd4;
        tick();
        runs_in = 3'd0;
        check("chg.team", int'(team), 1);
        check("chg.inning", int'(inning), 1);
        check("chg.pe2", int'(play_enable), 1);
        check("chg.hc2", int'(half_clear_pulse), 0);
        check("chg.s1", int'(score1), 0);

        // Home leads 2-1 after top of 9: bottom half skipped.
        apply_reset();
        add_runs(3'd1);
        do_change();
        add_runs(3'd2);
        do_change();
        advance(14);
        check("skip.pre_team", int'(team), 0);
        check("skip.pre_inn", int'(inning), 9);
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("skip.go", int'(game_over), 1);
        check("skip.win", int'(winner), 2);
        check("skip.hc", int'(half_clear_pulse), 0);
        check("skip.pe", int'(play_enable), 0);
        check("skip.inn", int'(inning), 9);
        check("skip.team", int'(team), 0);
        tick();
        check("skip.hc2", int'(half_clear_pulse), 0);

        // Walk-off on a single run in bottom of 9 at 3-3.
        apply_reset();
        add_runs(3'd3);
        do_change();
        add_runs(3'd3);
        do_change();
        advance(15);
        check("wo.team", int'(team), 1);
        check("wo.inn", int'(inning), 9);
        check("wo.go_pre", int'(game_over), 0);
        add_runs(3'd1);
        check("wo.s1", int'(score1), 4);
        check("wo.go", int'(game_over), 1);
        check("wo.win", int'(winner), 2);
        change_pulse = 1'b1;
        runs_in      = 3'd4;
        tick();
        change_pulse = 1'b0;
        runs_in      = 3'd0;
        check("wo.ign_hc", int'(half_clear_pulse), 0);
        check("wo.ign_s1", int'(score1), 4);
        check("wo.ign_inn", int'(inning), 9);
        check("wo.ign_win", int'(winner), 2);

        // 0-0 through extra innings to the tie at inning 12.
        apply_reset();
        advance(17);
        check("tie.b9_team", int'(team), 1);
        check("tie.b9_inn", int'(inning), 9);
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("tie.b9_hc", int'(half_clear_pulse), 1);
        tick();
        check("tie.inn10", int'(inning), 10);
        check("tie.team10", int'(team), 0);
        check("tie.go10", int'(game_over), 0);
        advance(5);
        check("tie.b12_inn", int'(inning), 12);
        check("tie.b12_team", int'(team), 1);
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("tie.go", int'(game_over), 1);
        check("tie.win", int'(winner), 3);
        check("tie.inn", int'(inning), 12);
        check("tie.hc", int'(half_clear_pulse), 0);

        // Visitor holds a 1-0 lead through bottom of 9.
        apply_reset();
        add_runs(3'd1);
        advance(17);
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("vis.go", int'(game_over), 1);
        check("vis.win", int'(winner), 1);
        check("vis.inn", int'(inning), 9);

        // Runs and change in the same cycle: runs counted first, home walks off.
        apply_reset();
        add_runs(3'd1);
        advance(17);
        check("same.team", int'(team), 1);
        change_pulse = 1'b1;
        runs_in      = 3'd2;
        tick();
        change_pulse = 1'b0;
        runs_in      = 3'd0;
        check("same.s1", int'(score1), 2);
        check("same.go", int'(game_over), 1);
        check("same.win", int'(winner), 2);
        check("same.hc", int'(half_clear_pulse), 0);

        // Asynchronous reset while in CHANGE mid-game.
        apply_reset();
        add_runs(3'd2);
        do_change();
        add_runs(3'd1);
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        check("mid.hc_pre", int'(half_clear_pulse), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid");
        @(negedge clk_divided);
        reset_n = 1'b1;
        tick();
        check("mid.hc_post", int'(half_clear_pulse), 0);
        check("mid.pe_post", int'(play_enable), 1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
